// File: rtl/rr_grant_controller.sv
// Four-way round-robin arbiter: one registered grant at a time, released on done,
// request withdrawal, disable or hold-limit expiry, with a forced idle cycle between grants.
module rr_grant_controller #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       last_reg, last_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [1:0]       gnt_id_reg, gnt_id_next;
  logic [3:0]       gnt_reg, gnt_next;
  logic             timeout_reg, timeout_next;

  logic [1:0] winner;
  logic       limit_hit;
  logic       early_rel;

  // Scan downwards so the last hit written is the nearest one after the pointer.
  always_comb begin
    winner = last_reg;
    for (int k = 3; k >= 0; k--) begin
      if (req[last_reg + 2'(k + 1)]) begin
        winner = last_reg + 2'(k + 1);
      end
    end
  end

  assign limit_hit = (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
  assign early_rel = done | ~req[gnt_id_reg] | ~ena;

  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    hold_cnt_next = hold_cnt_reg;
    gnt_id_next   = gnt_id_reg;
    gnt_next      = gnt_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        gnt_next = 4'b0000;
        if (ena && (req != 4'b0000)) begin
          state_next    = GRANT;
          gnt_id_next   = winner;
          gnt_next      = 4'b0001 << winner;
          hold_cnt_next = '0;
        end
      end
      GRANT: begin
        if (early_rel || limit_hit) begin
          state_next    = IDLE;
          gnt_next      = 4'b0000;
          last_next     = gnt_id_reg;
          hold_cnt_next = '0;
          // A timeout is reported only when nothing else would have ended the grant.
          timeout_next  = limit_hit & ~early_rel;
        end else begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      last_reg     <= 2'd3;
      hold_cnt_reg <= '0;
      gnt_id_reg   <= 2'd0;
      gnt_reg      <= 4'b0000;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      hold_cnt_reg <= hold_cnt_next;
      gnt_id_reg   <= gnt_id_next;
      gnt_reg      <= gnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_id    = gnt_id_reg;
  assign gnt_valid = (state_reg == GRANT);
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_grant_controller.sv
// Bench for rr_grant_controller: directed scenarios followed by random traffic,
// every cycle compared against a grant-level reference model.
module tb_rr_grant_controller;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who holds the resource, for how many cycles so far, and who went last.
  logic       m_valid;
  int         m_id;
  int         m_last;
  int         m_held;
  logic       m_to;

  rr_grant_controller #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_id    = 0;
    m_last  = 3;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge();
    logic limit;
    logic early;
    m_to = 1'b0;
    if (!m_valid) begin
      if (ena && req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (req[(m_last + k) % 4]) begin
            m_id = (m_last + k) % 4;
            break;
          end
        end
        m_valid = 1'b1;
        m_held  = 1;
      end
    end else begin
      limit = (m_held == MAX_HOLD);
      early = done || !req[m_id] || !ena;
      if (early || limit) begin
        m_valid = 1'b0;
        m_last  = m_id;
        m_to    = limit && !early;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] exp_gnt;
    exp_gnt = m_valid ? (4'b0001 << m_id) : 4'b0000;
    check("gnt", 8'(gnt), 8'(exp_gnt));
    check("gnt_id", 8'(gnt_id), 8'(m_id));
    check("gnt_valid", 8'(gnt_valid), 8'(m_valid));
    check("timeout", 8'(timeout), 8'(m_to));
    check("onehot", 8'($countones(gnt) <= 1), 8'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    $display("cyc req=%b ena=%b done=%b -> gnt=%b id=%0d v=%b to=%b", req, ena, done, gnt, gnt_id, gnt_valid, timeout);
  endtask

  initial begin
    int seq[$];
    int run;
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};

    // Reset held with everything requesting
    rst_n = 1'b0; ena = 1'b1; req = 4'b1111; done = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_gnt", 8'(gnt), 8'h0);
      check("rst_valid", 8'(gnt_valid), 8'h0);
      check("rst_timeout", 8'(timeout), 8'h0);
      check("rst_id", 8'(gnt_id), 8'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    check("first_winner", 8'(gnt_id), 8'd0);

    // Asynchronous reset in the middle of a grant
    step();
    rst_n = 1'b0;
    #1;
    check("async_gnt", 8'(gnt), 8'h0);
    check("async_valid", 8'(gnt_valid), 8'h0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // Round robin with done raised on every grant's first cycle
    done = 1'b1; req = 4'b1111;
    repeat (10) begin
      step();
      if (gnt_valid) seq.push_back(int'(gnt_id));
    end
    check("rr_count", 8'(seq.size()), 8'd5);
    for (int i = 0; i < 5 && i < seq.size(); i++) check("rr_order", 8'(seq[i]), 8'(exp_seq[i]));
    done = 1'b0; req = 4'b0000;
    repeat (2) step();

    // Single request then done pulse
    req = 4'b0100;
    step();
    check("single_gnt", 8'(gnt), 8'b0100);
    done = 1'b1;
    step();
    check("single_rel", 8'(gnt), 8'h0);
    done = 1'b0; req = 4'b0000;
    repeat (2) step();

    // Hold-limit timeout
    req = 4'b0010;
    step();
    run = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt_valid) run++;
      else break;
    end
    check("hold_len", 8'(run), 8'(MAX_HOLD));
    check("hold_to", 8'(timeout), 8'd1);
    step();
    check("regrant", 8'(gnt), 8'b0010);
    req = 4'b0000;
    repeat (2) step();

    // done arriving on the limit cycle wins over timeout
    req = 4'b0010;
    step();
    repeat (MAX_HOLD - 1) step();
    done = 1'b1;
    step();
    check("limit_done_to", 8'(timeout), 8'd0);
    check("limit_done_v", 8'(gnt_valid), 8'd0);
    done = 1'b0; req = 4'b0000;
    repeat (2) step();

    // Enable low blocks grants; dropping it mid-grant releases
    ena = 1'b0; req = 4'b1111;
    repeat (4) step();
    check("ena_off", 8'(gnt), 8'h0);
    ena = 1'b1;
    step();
    ena = 1'b0;
    step();
    check("ena_drop", 8'(gnt), 8'h0);
    ena = 1'b1; req = 4'b0000;
    repeat (2) step();

    // Withdrawal by requester 3, next scan starts at 0
    req = 4'b1000;
    step();
    check("gnt3", 8'(gnt_id), 8'd3);
    req = 4'b0111;
    step();
    check("wd_to", 8'(timeout), 8'd0);
    step();
    check("wd_next", 8'(gnt_id), 8'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      ena  = ($urandom_range(0, 7) != 0);
      done = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_grant_controller.md
Name: rr_grant_controller

Overview:
- Round-robin arbiter that shares one resource among 4 requesters, e.g. the row-select/update resource of the game-of-life datapath.
- Grants the resource to one requester at a time and holds the grant until that requester releases it or a hold timeout expires.
- Outputs the winner as a 2-bit index and as its one-hot decode.
- Sits between the requesting agents and the select-decode stage.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles a grant is held. Must be >= 1.
- CNT_W, $clog2(MAX_HOLD+1): width of the hold counter.

Ports:
- clk  input  1: the single clock; all logic is rising-edge.
- rst_n  input  1: reset, asynchronous and active-low.
- ena  input  1: arbiter enable. When low, no new grants are issued and any active grant is dropped.
- req  input  4: request vector; req[i] high means requester i wants the resource.
- done  input  1: release strobe from the current grant holder.
- gnt  output  4: one-hot grant; equals the decode of gnt_id when gnt_valid is high, otherwise 0000.
- gnt_id  output  2: index of the current or most recent grantee.
- gnt_valid  output  1: high while a grant is active.
- timeout  output  1: one-cycle pulse indicating the previous grant ended by timeout.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n low, takes effect immediately with no clock):
  - state = IDLE; gnt = 0000; gnt_id = 0; gnt_valid = 0; timeout = 0; hold_cnt = 0.
  - Priority pointer last = 3, so requester 0 has top priority after reset.
- Release of rst_n: the first active edge is the first clk rising edge with rst_n high.
- All outputs are registered; there is no combinational path from inputs to outputs.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - If ena is high and req is nonzero at an edge, pick the first set bit scanning (last+1), (last+2), ... mod 4 (wrap 3 -> 0).
  - At that same edge: state = GRANT, gnt_id = winner, gnt_valid = 1, hold_cnt = 0.
  - Latency: request sampled at edge N gives gnt valid after edge N (1 cycle).
  - Otherwise stay in IDLE with gnt = 0000.
- GRANT, evaluated at each edge:
  - Release conditions: done = 1, OR req[gnt_id] = 0, OR ena = 0, OR hold_cnt == MAX_HOLD-1.
  - On release: state = IDLE, gnt_valid = 0, gnt = 0000, last = gnt_id; gnt_id keeps its value.
  - Otherwise hold_cnt increments by 1.
- Hold length: a grant lasts at most MAX_HOLD cycles. With MAX_HOLD = 1, every grant lasts exactly 1 cycle.
- timeout:
  - Set to 1 at a release edge only when the hold limit is the sole release cause, i.e. done = 1 or req withdrawal or ena = 0 takes precedence.
  - Cleared at every other edge.
- Mandatory 1-cycle IDLE gap between consecutive grants, including a re-grant to the same requester. The gap guarantees gnt is never one-hot for two different requesters in adjacent cycles without a 0000 cycle between.
- Requests from non-holders during GRANT are ignored; they are arbitrated in the IDLE cycle after release.
- done while in IDLE is ignored.
- req bits may toggle at any time; the scan uses only the value sampled at the IDLE edge.
- Fairness: a continuously requesting agent waits at most 3 grants, i.e. <= 3*(MAX_HOLD+1) + 1 cycles.
- Reset asserted mid-grant: gnt drops to 0000 immediately (asynchronously) and the pointer returns to 3.
- Invariant: gnt == 0000 whenever gnt_valid == 0, and popcount(gnt) <= 1 always.

Test Plan:
- Reset: hold rst_n = 0 with req = 1111 and ena = 1 -> gnt = 0000, gnt_valid = 0, timeout = 0. Then pull rst_n low asynchronously mid-grant -> gnt = 0000 before the next edge; after release, first grant goes to requester 0.
- Single request: req = 0100, ena = 1 -> one edge later gnt = 0100, gnt_id = 2, gnt_valid = 1. Pulse done for one cycle -> gnt = 0000 after that edge, timeout = 0.
- Round-robin: req = 1111 held, done asserted on every grant's first cycle -> gnt_id sequence 0,1,2,3,0, with a gnt = 0000 cycle between each grant.
- Timeout, MAX_HOLD = 8: req = 0010 held, done = 0 -> gnt = 0010 for exactly 8 cycles, then gnt = 0000 with timeout = 1 for 1 cycle, then gnt = 0010 again.
- Timeout vs done at the limit cycle: done = 1 at hold_cnt = 7 -> release with timeout = 0.
- Enable and withdrawal:
  - ena = 0 with req = 1111 -> gnt stays 0000.
  - ena dropped mid-grant -> gnt = 0000 after the next edge.
  - req[3] dropped mid-grant of requester 3 -> release, timeout = 0; next winner scans from 0.
